debug_frame_ctrl: RTL and testbench

// - UART debug controller for the pipelined datapath: run/step/dump control, framed state upload.
// - Frame: header 0xA5, pipeline snapshot, RAM dump, 8-bit checksum.
// - Sits between the UART RX/TX FIFOs, the pipeline enable/reset and the RAM debug port.

---
 rtl/debug_frame_ctrl.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_debug_frame_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_frame_ctrl.sv
// debug_frame_ctrl: UART debug controller for the pipelined datapath.
// Decodes run/step/dump commands from the RX FIFO, drives pipeline enable and
// flush, and uploads a frame: header 0xA5, snapshot bytes, RAM dump, checksum.
// Optional breakpoint support is compiled in with `define DEBUG_BREAKPOINT_EN.
//
// Handshakes: rxRead pops the RX head only in a cycle where rxAvailable=1, and
// rxData is consumed in that same cycle. txWrite pushes txData only in a cycle
// where txFull=0; a byte is counted as sent exactly when txWrite=1.
module debug_frame_ctrl #(
  parameter int SNAP_BYTES = 75,
  parameter int MEM_WORDS  = 5,
  parameter int ADDR_W     = 8,
  parameter int CNT_W      = 8,
  parameter int SNAP_W     = 8 * SNAP_BYTES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rxData,
  input  logic              rxAvailable,
  output logic              rxRead,
  output logic [7:0]        txData,
  output logic              txWrite,
  input  logic              txFull,
  input  logic              endOfProgram,
  input  logic [ADDR_W-1:0] pcIn,
  input  logic [SNAP_W-1:0] snapData,
  input  logic [31:0]       memDataIn,
  output logic              dbgMemSel,
  output logic [ADDR_W-1:0] dbgMemAddr,
  output logic              pipeEnable,
  output logic              pipeReset,
  output logic [3:0]        ledState,
  output logic [CNT_W-1:0]  sendCounter,
  output logic              frameDone,
  output logic [3:0]        dbgState
);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_IDLE_BP, S_CONT, S_STEP, S_STEP_BP, S_STEP_RUN,
    S_HDR, S_SNAP, S_MEM, S_SUM
  } state_t;

  localparam logic [7:0] CH_C = 8'h63;  // 'c'
  localparam logic [7:0] CH_S = 8'h73;  // 's'
  localparam logic [7:0] CH_D = 8'h64;  // 'd'
  localparam logic [7:0] CH_N = 8'h6E;  // 'n'
  localparam logic [7:0] CH_R = 8'h72;  // 'r'
`ifdef DEBUG_BREAKPOINT_EN
  localparam logic [7:0] CH_B = 8'h62;  // 'b'
  localparam logic [7:0] CH_X = 8'h78;  // 'x'
`endif

  // Counter value of the last snapshot byte, first RAM byte and last RAM byte.
  localparam logic [CNT_W-1:0] SNAP_LAST = CNT_W'(SNAP_BYTES);
  localparam logic [CNT_W-1:0] MEM_BASE  = CNT_W'(SNAP_BYTES + 1);
  localparam logic [CNT_W-1:0] MEM_LAST  = CNT_W'(SNAP_BYTES + 4 * MEM_WORDS);

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       sum_q, sum_d;
  logic             mem_wait_q, mem_wait_d;
  logic             frame_done_q, frame_done_d;
  logic [7:0]       snap_byte;
  logic [7:0]       mem_byte;
  logic [CNT_W-1:0] mem_off;
  logic             bp_hit;

`ifdef DEBUG_BREAKPOINT_EN
  logic [ADDR_W-1:0] bp_addr_q, bp_addr_d;
  logic              bp_armed_q, bp_armed_d;

  assign bp_hit = bp_armed_q && (pcIn == bp_addr_q);

  // Breakpoint address and arm flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bp_addr_q  <= '0;
      bp_armed_q <= 1'b0;
    end else begin
      bp_addr_q  <= bp_addr_d;
      bp_armed_q <= bp_armed_d;
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^pcIn;
  assign bp_hit    = 1'b0;
`endif

  assign mem_off     = cnt_q - MEM_BASE;
  assign sendCounter = cnt_q;
  assign frameDone   = frame_done_q;
  assign dbgState    = state_q;

  // Select the snapshot byte addressed by the send counter (byte k at counter k+1).
  always_comb begin
    snap_byte = 8'h00;
    for (int k = 0; k < SNAP_BYTES; k++) begin
      if (cnt_q == CNT_W'(k + 1)) snap_byte = snapData[SNAP_W-1-8*k -: 8];
    end
  end

  // Select the RAM word byte, most significant byte first.
  always_comb begin
    case (mem_off[1:0])
      2'd0:    mem_byte = memDataIn[31:24];
      2'd1:    mem_byte = memDataIn[23:16];
      2'd2:    mem_byte = memDataIn[15:8];
      default: mem_byte = memDataIn[7:0];
    endcase
  end

  // State, frame counter, checksum and wait-cycle registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_INIT;
      ret_q        <= S_IDLE;
      cnt_q        <= '0;
      sum_q        <= 8'h00;
      mem_wait_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      cnt_q        <= cnt_d;
      sum_q        <= sum_d;
      mem_wait_q   <= mem_wait_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Command decode, pipeline control and frame sequencing.
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    mem_wait_d   = mem_wait_q;
    frame_done_d = 1'b0;
`ifdef DEBUG_BREAKPOINT_EN
    bp_addr_d    = bp_addr_q;
    bp_armed_d   = bp_armed_q;
`endif
    rxRead       = 1'b0;
    txWrite      = 1'b0;
    txData       = 8'h00;
    pipeEnable   = 1'b0;
    pipeReset    = 1'b0;
    dbgMemSel    = 1'b0;
    dbgMemAddr   = '0;
    ledState     = 4'b0000;

    case (state_q)
      S_INIT: begin
        pipeReset = 1'b1;
        state_d   = S_IDLE;
      end

      S_IDLE: begin
        pipeReset = 1'b1;
        ledState  = 4'b0001;
        if (rxAvailable) begin
          rxRead = 1'b1;
          case (rxData)
            CH_C: state_d = S_CONT;
            CH_S: state_d = S_STEP;
            CH_D: begin
              state_d = S_HDR;
              ret_d   = S_IDLE;
            end
`ifdef DEBUG_BREAKPOINT_EN
            CH_B: state_d = S_IDLE_BP;
            CH_X: bp_armed_d = 1'b0;
`endif
            default: ;
          endcase
        end
      end

`ifdef DEBUG_BREAKPOINT_EN
      S_IDLE_BP, S_STEP_BP: begin
        pipeReset = (state_q == S_IDLE_BP);
        ledState  = (state_q == S_IDLE_BP) ? 4'b0001 : 4'b0010;
        if (rxAvailable) begin
          rxRead     = 1'b1;
          bp_addr_d  = rxData[ADDR_W-1:0];
          bp_armed_d = 1'b1;
          state_d    = (state_q == S_IDLE_BP) ? S_IDLE : S_STEP;
        end
      end
`endif

      S_CONT: begin
        ledState = 4'b0100;
        // The pipe is held in the exit cycle so it never advances past a hit.
        if (endOfProgram) begin
          state_d = S_HDR;
          ret_d   = S_IDLE;
        end else if (bp_hit) begin
          state_d = S_HDR;
          ret_d   = S_STEP;
        end else begin
          pipeEnable = 1'b1;
        end
`ifdef DEBUG_BREAKPOINT_EN
        if (bp_hit) bp_armed_d = 1'b0;
`endif
      end

      S_STEP: begin
        ledState = 4'b0010;
        if (rxAvailable) begin
          rxRead = 1'b1;
          case (rxData)
            CH_N: state_d = S_STEP_RUN;
            CH_R: state_d = S_IDLE;
`ifdef DEBUG_BREAKPOINT_EN
            CH_B: state_d = S_STEP_BP;
            CH_X: bp_armed_d = 1'b0;
`endif
            default: ;
          endcase
        end
      end

      S_STEP_RUN: begin
        ledState   = 4'b0010;
        pipeEnable = 1'b1;
        state_d    = S_HDR;
        ret_d      = endOfProgram ? S_IDLE : S_STEP;
      end

      S_HDR: begin
        ledState = 4'b1000;
        txData   = 8'hA5;
        sum_d    = 8'h00;
        if (!txFull) begin
          txWrite = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_SNAP;
        end
      end

      S_SNAP: begin
        ledState = 4'b1000;
        txData   = snap_byte;
        if (!txFull) begin
          txWrite = 1'b1;
          sum_d   = sum_q + snap_byte;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == SNAP_LAST) begin
            state_d    = S_MEM;
            mem_wait_d = 1'b1;
          end
        end
      end

      S_MEM: begin
        ledState   = 4'b1000;
        dbgMemSel  = 1'b1;
        dbgMemAddr = ADDR_W'(mem_off[CNT_W-1:2]);
        txData     = mem_byte;
        // The first cycle on each new word address lets the RAM read settle.
        if (mem_wait_q) begin
          mem_wait_d = 1'b0;
        end else if (!txFull) begin
          txWrite = 1'b1;
          sum_d   = sum_q + mem_byte;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == MEM_LAST) begin
            state_d = S_SUM;
          end else if (mem_off[1:0] == 2'd3) begin
            mem_wait_d = 1'b1;
          end
        end
      end

      S_SUM: begin
        ledState = 4'b1000;
        txData   = sum_q;
        if (!txFull) begin
          txWrite      = 1'b1;
          cnt_d        = '0;
          frame_done_d = 1'b1;
          state_d      = ret_q;
        end
      end

      default: state_d = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_debug_frame_ctrl.sv
// Bench for debug_frame_ctrl: table of dump frames plus hand-written step,
// continue, stall, reset-abort and (when DEBUG_BREAKPOINT_EN is defined)
// breakpoint sequences. Frame bytes are checked against an expected queue.
module tb_debug_frame_ctrl;
  localparam int SNAP_BYTES = 75;
  localparam int MEM_WORDS  = 5;
  localparam int ADDR_W     = 8;
  localparam int CNT_W      = 8;
  localparam int SNAP_W     = 8 * SNAP_BYTES;
  localparam int FRAME_LEN  = SNAP_BYTES + 4 * MEM_WORDS + 2;

  logic              clock, reset;
  logic [7:0]        rxData;
  logic              rxAvailable, rxRead;
  logic [7:0]        txData;
  logic              txWrite, txFull;
  logic              endOfProgram;
  logic [ADDR_W-1:0] pcIn;
  logic [SNAP_W-1:0] snapData;
  logic [31:0]       memDataIn;
  logic              dbgMemSel;
  logic [ADDR_W-1:0] dbgMemAddr;
  logic              pipeEnable, pipeReset;
  logic [3:0]        ledState;
  logic [CNT_W-1:0]  sendCounter;
  logic              frameDone;
  logic [3:0]        dbgState;

  debug_frame_ctrl #(
    .SNAP_BYTES(SNAP_BYTES), .MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .rxData(rxData), .rxAvailable(rxAvailable),
    .rxRead(rxRead), .txData(txData), .txWrite(txWrite), .txFull(txFull),
    .endOfProgram(endOfProgram), .pcIn(pcIn), .snapData(snapData),
    .memDataIn(memDataIn), .dbgMemSel(dbgMemSel), .dbgMemAddr(dbgMemAddr),
    .pipeEnable(pipeEnable), .pipeReset(pipeReset), .ledState(ledState),
    .sendCounter(sendCounter), .frameDone(frameDone), .dbgState(dbgState)
  );

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  blast;
    logic [31:0] m0;
    logic [31:0] m4;
    int          stall;
    logic [7:0]  sum;
  } vec_t;

  vec_t        vecs[5];
  logic [7:0]  snap_b[SNAP_BYTES];
  logic [31:0] mem_m[MEM_WORDS];
  logic [7:0]  exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          byte_idx = 0;
  int          frames_seen = 0;
  int          pe_cnt = 0;
  int          stall_mode = 0;
  logic        done_exp = 1'b0;
  logic        pc_clear = 1'b1;

  // ---------------- clock / reset-independent models ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model: read data one cycle after the address.
  always @(posedge clock)
    memDataIn <= (int'(dbgMemAddr) < MEM_WORDS) ? mem_m[dbgMemAddr] : 32'h0;

  // Pipeline PC model: advances once per enabled cycle.
  always @(posedge clock)
    if (pc_clear) pcIn <= '0;
    else if (pipeEnable) pcIn <= pcIn + 1'b1;

  // TX FIFO full model: 0 = never full, 1 = toggle each cycle, 2 = held full.
  initial begin
    txFull = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (stall_mode)
        1:       txFull = ~txFull;
        2:       txFull = 1'b1;
        default: txFull = 1'b0;
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (!reset) begin
      byte_idx = 0;
      done_exp = 1'b0;
    end else begin
      if (done_exp || frameDone) begin
        checks++;
        if (frameDone !== done_exp) begin
          failures++;
          $display("FAIL frame_done act=%b exp=%b", frameDone, done_exp);
        end
      end
      done_exp = 1'b0;
      if (pipeEnable) pe_cnt++;
      if (txWrite) begin
        checks++;
        if (txFull) begin
          failures++;
          $display("FAIL write_when_full act=1 exp=0");
        end
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_byte act=%02h exp=none", txData);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          checks++;
          if (txData !== e) begin
            failures++;
            $display("FAIL tx_byte[%0d] act=%02h exp=%02h", byte_idx, txData, e);
          end
          checks++;
          if (int'(sendCounter) != byte_idx) begin
            failures++;
            $display("FAIL send_counter act=%0d exp=%0d", sendCounter, byte_idx);
          end
          byte_idx++;
          if (byte_idx == FRAME_LEN) begin
            byte_idx = 0;
            done_exp = 1'b1;
            frames_seen++;
          end
        end
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bit popped;
    popped = 1'b0;
    @(negedge clock);
    rxData      = b;
    rxAvailable = 1'b1;
    for (int i = 0; i < 200 && !popped; i++) begin
      #1;
      if (rxRead) begin
        @(posedge clock);
        #1;
        popped = 1'b1;
      end else begin
        @(negedge clock);
      end
    end
    rxAvailable = 1'b0;
    chk("rx_pop", {31'h0, popped}, 32'h1);
  endtask

  task automatic load_vec(input vec_t v);
    for (int k = 0; k < SNAP_BYTES; k++) snap_b[k] = 8'h00;
    snap_b[0] = v.b0;
    snap_b[SNAP_BYTES-1] = v.blast;
    for (int w = 0; w < MEM_WORDS; w++) mem_m[w] = 32'h0;
    mem_m[0] = v.m0;
    mem_m[MEM_WORDS-1] = v.m4;
    for (int k = 0; k < SNAP_BYTES; k++) snapData[SNAP_W-1-8*k -: 8] = snap_b[k];
  endtask

  task automatic push_frame(input logic [7:0] sum);
    logic [31:0] wd;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < SNAP_BYTES; k++) exp_q.push_back(snap_b[k]);
    for (int w = 0; w < MEM_WORDS; w++) begin
      wd = mem_m[w];
      for (int b = 0; b < 4; b++) exp_q.push_back(wd[31-8*b -: 8]);
    end
    exp_q.push_back(sum);
  endtask

  // Waits for the frame to complete, then returns just after the checksum push.
  task automatic wait_frame(input string name);
    int target;
    int n;
    target = frames_seen + 1;
    n = 0;
    while (frames_seen < target && n < 3000) begin
      @(negedge clock);
      #2;
      n++;
    end
    chk({name, "_timeout"}, {31'h0, frames_seen >= target}, 32'h1);
    @(negedge clock);
    #1;
    chk({name, "_queue_empty"}, exp_q.size(), 32'h0);
    chk({name, "_counter_clear"}, {24'h0, sendCounter}, 32'h0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{8'h12, 8'h00, 32'h01020304, 32'h00000000, 0, 8'h1C};
    vecs[1] = '{8'h12, 8'h00, 32'h01020304, 32'h00000000, 1, 8'h1C};
    vecs[2] = '{8'hFF, 8'h01, 32'h00000000, 32'hFFFFFFFF, 0, 8'hFC};
    vecs[3] = '{8'h80, 8'h80, 32'h80000000, 32'h00000080, 1, 8'h00};
    vecs[4] = '{8'h5A, 8'h33, 32'h11223344, 32'h00000000, 0, 8'h37};

    reset = 1'b0; rxData = 8'h00; rxAvailable = 1'b0; endOfProgram = 1'b0;
    snapData = '0;
    load_vec(vecs[0]);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_pipe_reset", {31'h0, pipeReset}, 32'h1);
    chk("rst_tx_write", {31'h0, txWrite}, 32'h0);
    chk("rst_led", {28'h0, ledState}, 32'h0);
    chk("rst_pipe_enable", {31'h0, pipeEnable}, 32'h0);
    chk("rst_rx_read", {31'h0, rxRead}, 32'h0);
    chk("rst_frame_done", {31'h0, frameDone}, 32'h0);
    chk("rst_counter", {24'h0, sendCounter}, 32'h0);
    reset = 1'b1;
    pc_clear = 1'b0;
    @(negedge clock);
    chk("idle_led", {28'h0, ledState}, 32'h1);
    chk("idle_pipe_reset", {31'h0, pipeReset}, 32'h1);

    // Table of dump frames from IDLE.
    for (int i = 0; i < 5; i++) begin
      load_vec(vecs[i]);
      stall_mode = vecs[i].stall;
      push_frame(vecs[i].sum);
      rx_byte(8'h64);
      wait_frame($sformatf("dump%0d", i));
      stall_mode = 0;
      chk($sformatf("dump%0d_led", i), {28'h0, ledState}, 32'h1);
    end

    // Single step: one cycle of pipeEnable, frame, back in STEP.
    load_vec(vecs[0]);
    rx_byte(8'h73);
    @(negedge clock); #1;
    chk("step_led", {28'h0, ledState}, 32'h2);
    chk("step_pipe_enable", {31'h0, pipeEnable}, 32'h0);
    push_frame(vecs[0].sum);
    pe_cnt = 0;
    rx_byte(8'h6E);
    wait_frame("step");
    chk("step_pe_cycles", pe_cnt, 32'h1);
    chk("step_return_led", {28'h0, ledState}, 32'h2);
    rx_byte(8'h72);
    @(negedge clock); #1;
    chk("step_r_led", {28'h0, ledState}, 32'h1);

    // TX FIFO held full: no writes, counter held, then the full frame.
    stall_mode = 2;
    push_frame(vecs[0].sum);
    rx_byte(8'h64);
    repeat (40) @(negedge clock);
    #1;
    chk("full_led", {28'h0, ledState}, 32'h8);
    chk("full_counter", {24'h0, sendCounter}, 32'h0);
    chk("full_tx_write", {31'h0, txWrite}, 32'h0);
    stall_mode = 0;
    wait_frame("full");
    chk("full_return_led", {28'h0, ledState}, 32'h1);

    // Continue until endOfProgram at cycle 20.
    push_frame(vecs[0].sum);
    rx_byte(8'h63);
    @(negedge clock); #1;
    chk("cont_led", {28'h0, ledState}, 32'h4);
    chk("cont_pipe_enable", {31'h0, pipeEnable}, 32'h1);
    repeat (18) @(negedge clock);
    endOfProgram = 1'b1;
    #1;
    chk("cont_exit_pe", {31'h0, pipeEnable}, 32'h0);
    pe_cnt = 0;
    wait_frame("cont");
    chk("cont_pe_after_exit", pe_cnt, 32'h0);
    chk("cont_return_led", {28'h0, ledState}, 32'h1);
    endOfProgram = 1'b0;

    // Reset in the middle of a frame aborts it.
    push_frame(vecs[0].sum);
    rx_byte(8'h64);
    repeat (30) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_led", {28'h0, ledState}, 32'h0);
    chk("abort_tx_write", {31'h0, txWrite}, 32'h0);
    chk("abort_counter", {24'h0, sendCounter}, 32'h0);
    chk("abort_pipe_reset", {31'h0, pipeReset}, 32'h1);
    exp_q.delete();
    @(negedge clock);
    #2;
    reset = 1'b1;
    @(negedge clock); #1;
    chk("abort_idle_led", {28'h0, ledState}, 32'h1);
    load_vec(vecs[4]);
    push_frame(vecs[4].sum);
    rx_byte(8'h64);
    wait_frame("after_abort");

`ifdef DEBUG_BREAKPOINT_EN
    // Breakpoint at 0x10: frame, then STEP with the pipe stopped at the hit.
    pc_clear = 1'b1;
    repeat (2) @(negedge clock);
    pc_clear = 1'b0;
    load_vec(vecs[0]);
    rx_byte(8'h62);
    rx_byte(8'h10);
    push_frame(vecs[0].sum);
    rx_byte(8'h63);
    wait_frame("bp");
    chk("bp_return_led", {28'h0, ledState}, 32'h2);
    chk("bp_pc", {24'h0, pcIn}, 32'h10);
    // Disarmed: continuing from the hit address must not stop again.
    rx_byte(8'h72);
    rx_byte(8'h63);
    repeat (5) @(negedge clock);
    #1;
    chk("bp_disarmed_led", {28'h0, ledState}, 32'h4);
    push_frame(vecs[0].sum);
    endOfProgram = 1'b1;
    wait_frame("bp_end");
    endOfProgram = 1'b0;
    chk("bp_end_led", {28'h0, ledState}, 32'h1);
`endif

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
